// File: rtl/mvau_pkg.sv
// mvau_pkg: types and constants shared by the MVAU weight-fetch files.
//   wword_t  : one weight word (SIMD*TW bits) for the default lane shape
//   wentry_t : a buffered {data, last} stream entry
//   OCC_*    : occupancy codes for the 2-entry re-timing buffer
package mvau_pkg;

   localparam int unsigned MVAU_SIMD = 2;
   localparam int unsigned MVAU_TW   = 1;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   typedef logic [MVAU_SIMD*MVAU_TW-1:0] wword_t;

   typedef struct packed {
      wword_t data;
      logic   last;
   } wentry_t;

endpackage

// File: rtl/mvau_wfetch_fifo.sv
// mvau_wfetch_fifo: 2-entry register FIFO that absorbs consumer back-pressure.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush, wins over push and pop
//   push     : write din this edge
//   pop      : drop the head entry this edge
//   din      : entry to write (EW bits)
//   head     : oldest entry, straight from a register
//   occ      : number of stored entries (0..2)
module mvau_wfetch_fifo
   import mvau_pkg::*;
#(
   parameter int unsigned EW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] din,
   output logic [EW-1:0] head,
   output logic [1:0]    occ
);

   logic [EW-1:0] ent0;   // head slot
   logic [EW-1:0] ent1;   // second slot

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ  <= OCC_EMPTY;
         ent0 <= '0;
         ent1 <= '0;
      end else if (clr) begin
         occ <= OCC_EMPTY;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (occ == OCC_EMPTY) ent0 <= din;
               else                  ent1 <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: the new entry lands behind whatever
               // survives the pop, so it goes to the head when only one was held.
               if (occ == OCC_FULL) begin
                  ent0 <= ent1;
                  ent1 <= din;
               end else begin
                  ent0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = ent0;

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && occ == OCC_FULL));
   a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      !(pop && occ == OCC_EMPTY));

endmodule

// File: rtl/mvau_weight_fetch.sv
// mvau_weight_fetch: weight-memory address generator and ready/valid re-timer
// for one MVAU PE lane.
//   aclk, areset : clock, asynchronous active-high reset
//   clr          : synchronous stream restart (next word delivered is address 0)
//   wmem_addr    : registered read address to the 1-cycle-latency weight memory
//   wmem_data    : memory output for the address presented at the previous edge
//   wf_tdata     : weight word
//   wf_tvalid    : word available
//   wf_tready    : consumer accepts the word
//   wf_tlast     : word came from address WMEM_DEPTH-1
// WMEM_DEPTH must be >= 2 and fit in WMEM_ADDR_BW bits.
module mvau_weight_fetch
   import mvau_pkg::*;
#(
   parameter int unsigned SIMD         = 2,
   parameter int unsigned TW           = 1,
   parameter int unsigned WMEM_DEPTH   = 4,
   parameter int unsigned WMEM_ADDR_BW = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    clr,
   output logic [WMEM_ADDR_BW-1:0] wmem_addr,
   input  logic [SIMD*TW-1:0]      wmem_data,
   output logic [SIMD*TW-1:0]      wf_tdata,
   output logic                    wf_tvalid,
   input  logic                    wf_tready,
   output logic                    wf_tlast
);

   typedef struct packed {
      logic [SIMD*TW-1:0] data;
      logic               last;
   } entry_t;

   localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

   logic       rd_vld;     // read issued last edge returns data this cycle
   logic       last_tag;   // last flag travelling alongside the in-flight read
   logic       rd_en;
   logic       pop;
   logic [1:0] occ;
   logic [2:0] demand;
   entry_t     din;
   entry_t     head;

   assign pop = wf_tvalid & wf_tready;

   // Issue a read only if the buffer can still take it once everything
   // already stored or in flight is counted, net of this cycle's pop.
   assign demand = 3'(occ) + 3'(rd_vld) - 3'(pop);
   assign rd_en  = !clr && (demand < {1'b0, OCC_FULL});

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wmem_addr <= '0;
         rd_vld    <= 1'b0;
         last_tag  <= 1'b0;
      end else if (clr) begin
         wmem_addr <= '0;
         rd_vld    <= 1'b0;
      end else if (rd_en) begin
         rd_vld    <= 1'b1;
         last_tag  <= (wmem_addr == LAST_ADDR);
         wmem_addr <= (wmem_addr == LAST_ADDR) ? '0 : wmem_addr + 1'b1;
      end else begin
         rd_vld <= 1'b0;
      end
   end

   always_comb begin
      din      = '0;
      din.data = wmem_data;
      din.last = last_tag;
   end

   mvau_wfetch_fifo #(
      .EW($bits(entry_t))
   ) u_fifo (
      .clk  (aclk),
      .rst  (areset),
      .clr  (clr),
      .push (rd_vld),
      .pop  (pop),
      .din  (din),
      .head (head),
      .occ  (occ)
   );

   assign wf_tvalid = (occ != OCC_EMPTY);
   assign wf_tdata  = head.data;
   assign wf_tlast  = head.last;

endmodule

// File: tb/tb_mvau_weight_fetch.sv
// tb_mvau_weight_fetch: directed bench for mvau_weight_fetch.
//   dut  : SIMD=2, TW=2, WMEM_DEPTH=4, memory word n = n
//   dut2 : SIMD=2, TW=2, WMEM_DEPTH=2, memory {addr0: 2, addr1: 1}
module tb_mvau_weight_fetch;

   logic       aclk = 1'b0;
   logic       areset;
   logic       clr;
   logic       tready;
   logic       tready2;

   logic [3:0] wmem_addr;
   logic [3:0] wmem_data;
   logic [3:0] tdata;
   logic       tvalid;
   logic       tlast;

   logic [0:0] wmem_addr2;
   logic [3:0] wmem_data2;
   logic [3:0] tdata2;
   logic       tvalid2;
   logic       tlast2;

   int n_cmp = 0;
   int n_err = 0;
   int exp_idx = 0;
   int n_last = 0;
   int idx2 = 0;
   int start;

   always #5 aclk = ~aclk;

   // Synchronous 1-cycle memories
   always @(posedge aclk) wmem_data  <= 4'(wmem_addr);
   always @(posedge aclk) wmem_data2 <= (wmem_addr2 == 1'b1) ? 4'h1 : 4'h2;

   mvau_weight_fetch #(
      .SIMD(2), .TW(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)
   ) dut (
      .aclk(aclk), .areset(areset), .clr(clr),
      .wmem_addr(wmem_addr), .wmem_data(wmem_data),
      .wf_tdata(tdata), .wf_tvalid(tvalid), .wf_tready(tready), .wf_tlast(tlast)
   );

   mvau_weight_fetch #(
      .SIMD(2), .TW(2), .WMEM_DEPTH(2), .WMEM_ADDR_BW(1)
   ) dut2 (
      .aclk(aclk), .areset(areset), .clr(clr),
      .wmem_addr(wmem_addr2), .wmem_data(wmem_data2),
      .wf_tdata(tdata2), .wf_tvalid(tvalid2), .wf_tready(tready2), .wf_tlast(tlast2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // At a falling edge: score the word the coming edge will accept, then
   // set tready for that edge. Returns with the pre-edge state visible.
   task automatic cyc(input logic tr);
      @(negedge aclk);
      tready = tr;
      if (tvalid && tr) begin
         chk("word", 32'(tdata), 32'(exp_idx % 4));
         chk("last", 32'(tlast), 32'((exp_idx % 4) == 3));
         if (tlast) n_last++;
         exp_idx++;
      end
   endtask

   task automatic cyc2(input logic tr);
      @(negedge aclk);
      tready2 = tr;
      if (tvalid2 && tr) begin
         chk("d2_word", 32'(tdata2), (idx2 % 2 == 0) ? 32'h2 : 32'h1);
         chk("d2_last", 32'(tlast2), 32'(idx2 % 2 == 1));
         idx2++;
      end
   endtask

   // clr pulse with tready high; the handshake in the clr cycle is not scored
   task automatic clr_pulse();
      @(negedge aclk);
      clr = 1'b1;
      tready = 1'b1;
      @(negedge aclk);
      clr = 1'b0;
      chk("clr_tvalid0", 32'(tvalid), 32'h0);
      chk("clr_addr0", 32'(wmem_addr), 32'h0);
      @(negedge aclk);
      chk("clr_tvalid1", 32'(tvalid), 32'h0);
      chk("clr_addr1", 32'(wmem_addr), 32'h1);
      exp_idx = 0;
      cyc(1'b1);
      chk("clr_restart", 32'(tvalid), 32'h1);
   endtask

   initial begin
      areset = 1'b1; clr = 1'b0; tready = 1'b0; tready2 = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_tvalid", 32'(tvalid), 32'h0);
      chk("rst_tlast", 32'(tlast), 32'h0);
      chk("rst_addr", 32'(wmem_addr), 32'h0);
      chk("rst_occ", 32'(dut.u_fifo.occ), 32'h0);

      // Reset release with tready=1: E0 issues addr 0, word 0 visible after E1
      @(negedge aclk);
      areset = 1'b0;
      tready = 1'b1;
      cyc(1'b1);
      chk("e0_tvalid", 32'(tvalid), 32'h0);
      chk("e0_addr", 32'(wmem_addr), 32'h1);
      cyc(1'b1);
      chk("e1_tvalid", 32'(tvalid), 32'h1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1);
         chk("stream_tvalid", 32'(tvalid), 32'h1);
      end

      // Word 9 (value 1) is presented; stall 10 cycles
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0);
         chk("stall_tdata", 32'(tdata), 32'h1);
         chk("stall_tvalid", 32'(tvalid), 32'h1);
         chk("stall_addr", 32'(wmem_addr), 32'h3);
         if (i > 0) chk("stall_occ", 32'(dut.u_fifo.occ), 32'h2);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1);
         chk("resume_tvalid", 32'(tvalid), 32'h1);
      end

      // Random tready over 1000 words
      start = exp_idx;
      n_last = 0;
      for (int c = 0; c < 6000 && exp_idx < start + 1000; c++)
         cyc(1'($urandom_range(0, 1)));
      chk("rand_words", 32'(exp_idx - start), 32'd1000);
      chk("rand_tlast_cnt", 32'(n_last), 32'd250);

      // clr with the buffer full
      repeat (3) cyc(1'b0);
      chk("pre_clr_occ", 32'(dut.u_fifo.occ), 32'h2);
      clr_pulse();
      for (int i = 0; i < 6; i++) cyc(1'b1);

      // clr in steady state with a read in flight
      chk("pre_clr2_rdvld", 32'(dut.rd_vld), 32'h1);
      clr_pulse();
      for (int i = 0; i < 6; i++) cyc(1'b1);

      // Asynchronous reset mid-stream
      @(negedge aclk);
      #2 areset = 1'b1;
      #1;
      chk("arst_tvalid", 32'(tvalid), 32'h0);
      chk("arst_addr", 32'(wmem_addr), 32'h0);
      chk("arst_tlast", 32'(tlast), 32'h0);
      @(negedge aclk);
      areset = 1'b0;
      tready = 1'b1;
      exp_idx = 0;
      cyc(1'b1);
      chk("arst_e0_tvalid", 32'(tvalid), 32'h0);
      chk("arst_e0_addr", 32'(wmem_addr), 32'h1);
      cyc(1'b1);
      chk("arst_e1_tvalid", 32'(tvalid), 32'h1);
      for (int i = 0; i < 5; i++) cyc(1'b1);
      chk("arst_words", 32'(exp_idx), 32'd6);

      // WMEM_DEPTH=2 with tready toggling every cycle
      @(negedge aclk);
      areset = 1'b1;
      tready2 = 1'b0;
      @(negedge aclk);
      chk("d2_rst_addr", 32'(wmem_addr2), 32'h0);
      chk("d2_rst_tvalid", 32'(tvalid2), 32'h0);
      areset = 1'b0;
      for (int c = 0; c < 100 && idx2 < 8; c++) cyc2(1'(c % 2));
      chk("d2_words", 32'(idx2), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
